fpu_fcmp_wb: RTL and testbench

Writeback and exception sequencer for FPU compare results. Consumes the eq/gt/invalid/unordered flags produced by the FPU comparator for FCMP/EQ and FCMP/GT and turns them into a T-bit write and FPSCR invalid (V) cause/flag updates. Raises a held invalid-operation exception request toward the CPU exception unit and stalls further compares until it is acknowledged. Sits between the FPU compare datapath and the integer-pipeline SR.T / FPSCR write ports.

---
 rtl/fpu_fcmp_wb.sv | 127 ++++++++++++
 tb/tb_fpu_fcmp_wb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_fcmp_wb.sv
// fpu_fcmp_wb -- writeback and exception sequencer for FPU compare results.
//
// This block takes the comparator flags for FCMP/EQ and FCMP/GT and turns
// them into an SR.T write strobe plus FPSCR invalid (V) cause/flag updates.
// When an invalid compare occurs and the invalid trap is enabled, it raises
// a held exception request and stalls further compares until the request
// is acknowledged.
//
// Configuration macro:
//   FPU_FCMP_GT_QNAN_INV_EN  When defined, FCMP/GT with any NaN operand
//                            (quiet or signalling) is invalid (SH-4
//                            behaviour). When undefined, only signalling
//                            NaNs are invalid for both opcodes.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   i_valid / i_ready   compare result handshake (i_ready = IDLE)
//   i_op                0 = FCMP/EQ, 1 = FCMP/GT
//   i_eq, i_gt          comparator relations
//   i_invalid           signalling NaN operand
//   i_unordered         at least one NaN operand
//   i_flush             discard the input offered this cycle
//   fpscr_en_v          FPSCR.Enable.V (invalid trap enable)
//   fpscr_we            software write of FPSCR flag field
//   fpscr_flag_v_wdata  new FPSCR.Flag.V value on fpscr_we
//   t_we, t_val         one-cycle T-bit write strobe and value
//   cause_v             FPSCR.Cause.V of the last accepted compare
//   flag_v              sticky FPSCR.Flag.V
//   exc_req, exc_ack    invalid-operation exception request/acknowledge

module fpu_fcmp_wb (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  output logic i_ready,
  input  logic i_op,
  input  logic i_eq,
  input  logic i_gt,
  input  logic i_invalid,
  input  logic i_unordered,
  input  logic i_flush,
  input  logic fpscr_en_v,
  input  logic fpscr_we,
  input  logic fpscr_flag_v_wdata,
  output logic t_we,
  output logic t_val,
  output logic cause_v,
  output logic flag_v,
  output logic exc_req,
  input  logic exc_ack
);

`ifdef FPU_FCMP_GT_QNAN_INV_EN
  localparam logic GT_QNAN_TERM = 1'b1;
`else
  localparam logic GT_QNAN_TERM = 1'b0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    EXC  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic accept;
  logic inv;
  logic trap;
  logic t_res;

  assign accept = i_valid & i_ready & ~i_flush;
  assign inv    = i_invalid | (i_op & i_unordered & GT_QNAN_TERM);
  assign trap   = inv & fpscr_en_v;
  // Unordered compares always write T = 0, regardless of eq/gt flags.
  assign t_res  = i_unordered ? 1'b0 : (i_op ? i_gt : i_eq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    i_ready   = 1'b0;
    exc_req   = 1'b0;
    unique case (state)
      IDLE: begin
        i_ready = 1'b1;
        if (accept && trap) begin
          state_nxt = EXC;
        end
      end
      EXC: begin
        exc_req = 1'b1;
        if (exc_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_we    <= 1'b0;
      t_val   <= 1'b0;
      cause_v <= 1'b0;
      flag_v  <= 1'b0;
    end else begin
      t_we  <= accept & ~trap;
      t_val <= accept & ~trap & t_res;
      if (accept) begin
        cause_v <= inv;
      end
      // Software write takes priority over the sticky update from a compare.
      if (fpscr_we) begin
        flag_v <= fpscr_flag_v_wdata;
      end else if (accept && !trap && inv) begin
        flag_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_fcmp_wb.sv
// Self-checking bench for fpu_fcmp_wb: directed steps followed by random
// stimulus, checked against a behavioural model of the compare writeback.
module tb_fpu_fcmp_wb;

`ifdef FPU_FCMP_GT_QNAN_INV_EN
  localparam bit QNAN_GT_INV = 1'b1;
`else
  localparam bit QNAN_GT_INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_valid = 1'b0, i_ready;
  logic i_op = 1'b0, i_eq = 1'b0, i_gt = 1'b0, i_invalid = 1'b0, i_unordered = 1'b0;
  logic i_flush = 1'b0;
  logic fpscr_en_v = 1'b0, fpscr_we = 1'b0, fpscr_flag_v_wdata = 1'b0;
  logic t_we, t_val, cause_v, flag_v, exc_req;
  logic exc_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  // Model state
  bit m_exc, m_cause, m_flag, m_twe, m_tval;

  fpu_fcmp_wb dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_op(i_op),
    .i_eq(i_eq), .i_gt(i_gt), .i_invalid(i_invalid), .i_unordered(i_unordered),
    .i_flush(i_flush), .fpscr_en_v(fpscr_en_v), .fpscr_we(fpscr_we),
    .fpscr_flag_v_wdata(fpscr_flag_v_wdata),
    .t_we(t_we), .t_val(t_val), .cause_v(cause_v), .flag_v(flag_v),
    .exc_req(exc_req), .exc_ack(exc_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".i_ready"}, i_ready, !m_exc);
    chk({tag, ".exc_req"}, exc_req, m_exc);
    chk({tag, ".t_we"},    t_we,    m_twe);
    if (m_twe) chk({tag, ".t_val"}, t_val, m_tval);
    chk({tag, ".cause_v"}, cause_v, m_cause);
    chk({tag, ".flag_v"},  flag_v,  m_flag);
  endtask

  task automatic model_reset();
    m_exc = 0; m_cause = 0; m_flag = 0; m_twe = 0; m_tval = 0;
  endtask

  // Predict the effect of the inputs currently driven, advance one clock,
  // then compare. Inputs are only changed on the falling edge.
  task automatic cyc(input string tag);
    bit take, invalid_op, trapping, tres;
    take       = i_valid && !m_exc && !i_flush;
    invalid_op = i_invalid || (i_op && i_unordered && QNAN_GT_INV);
    trapping   = invalid_op && fpscr_en_v;
    if (i_unordered) tres = 0;
    else if (i_op)   tres = i_gt;
    else             tres = i_eq;
    m_twe = 0;
    if (m_exc) begin
      if (exc_ack) m_exc = 0;
    end else if (take) begin
      m_cause = invalid_op;
      if (trapping) m_exc = 1;
      else begin
        m_twe  = 1;
        m_tval = tres;
        if (invalid_op) m_flag = 1;
      end
    end
    if (fpscr_we) m_flag = fpscr_flag_v_wdata;
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_valid = 0; i_op = 0; i_eq = 0; i_gt = 0; i_invalid = 0; i_unordered = 0;
    i_flush = 0; fpscr_en_v = 0; fpscr_we = 0; fpscr_flag_v_wdata = 0; exc_ack = 0;
  endtask

  task automatic offer(input bit op, input bit eq, input bit gt, input bit inv, input bit unord);
    i_valid = 1; i_op = op; i_eq = eq; i_gt = gt; i_invalid = inv; i_unordered = unord;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_reset");

    // EQ true, then back-to-back GT false
    offer(0, 1, 0, 0, 0);
    cyc("eq_true");
    offer(1, 0, 0, 0, 0);
    cyc("gt_false");
    offer(1, 0, 1, 0, 0);
    cyc("gt_true");
    idle_inputs();
    cyc("idle1");

    // GT on quiet NaN, trap disabled
    offer(1, 0, 1, 0, 1);
    cyc("gt_qnan");
    idle_inputs();
    cyc("idle2");

    // Software write clears flag
    fpscr_we = 1; fpscr_flag_v_wdata = 0;
    cyc("sw_clear");
    idle_inputs();

    // EQ with sNaN, trap enabled -> EXC; hold ack low 5 cycles with input held
    offer(0, 0, 0, 1, 1); fpscr_en_v = 1;
    cyc("trap_enter");
    offer(0, 1, 0, 0, 0); fpscr_en_v = 0;
    for (int i = 0; i < 5; i++) cyc("exc_hold");
    i_flush = 1;               // flush ignored in EXC
    exc_ack = 1;
    cyc("exc_ack");
    exc_ack = 0; i_flush = 0;
    cyc("held_accept");
    idle_inputs();
    exc_ack = 1;
    cyc("ack_in_idle");
    idle_inputs();

    // Invalid non-trapping accept colliding with software write of 0
    offer(0, 0, 0, 1, 1); fpscr_we = 1; fpscr_flag_v_wdata = 0;
    cyc("sw_wins");
    idle_inputs();
    offer(0, 0, 0, 1, 1);
    cyc("sticky_set");
    idle_inputs();

    // Flushed offer changes nothing
    offer(0, 1, 0, 0, 0); i_flush = 1;
    cyc("flush");
    idle_inputs();
    cyc("idle3");

    // Reset while in EXC
    offer(1, 0, 0, 1, 0); fpscr_en_v = 1;
    cyc("trap_enter2");
    idle_inputs();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("after_reset");

    // Random stimulus
    for (int n = 0; n < 400; n++) begin
      i_valid            = ($urandom_range(3) != 0);
      i_op               = $urandom_range(1);
      i_unordered        = ($urandom_range(3) == 0);
      i_invalid          = i_unordered && ($urandom_range(1) == 1);
      i_eq               = $urandom_range(1);
      i_gt               = !i_eq && ($urandom_range(1) == 1);
      i_flush            = ($urandom_range(7) == 0);
      fpscr_en_v         = ($urandom_range(2) == 0);
      fpscr_we           = ($urandom_range(7) == 0);
      fpscr_flag_v_wdata = $urandom_range(1);
      exc_ack            = ($urandom_range(3) == 0);
      cyc("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
